crash_course_cpu_program_loader: RTL



---
 rtl/crash_course_cpu_program_loader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/crash_course_cpu_program_loader.sv
// Program loader for the crash-course CPU: turns a COUNT/data/CHECK byte
// stream into 16-bit program memory writes and gates the CPU reset.
module crash_course_cpu_program_loader #(
  parameter logic [7:0] BASE_ADDRESS = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        write_enable,
  output logic [7:0]  write_address,
  output logic [15:0] write_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 9;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] addr_q, addr_d;
  logic [BYTE_W-1:0] sum_q, sum_d;
  logic [BYTE_W-1:0] high_q, high_d;
  logic              we_q, we_d;
  logic [BYTE_W-1:0] waddr_q, waddr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              xfer;

  // State and output registers; a pending write is discarded by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      sum_q   <= '0;
      high_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sum_q   <= sum_d;
      high_q  <= high_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic: stream parsing, word assembly and checksum verdict.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    high_d  = high_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    err_d   = err_q;
    xfer    = byte_valid && ready_q;

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          state_d = S_COUNT;
          hold_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      S_COUNT: begin
        if (xfer) begin
          // A count byte of zero encodes a full 256-word image.
          cnt_d   = (byte_data == '0) ? CNT_W'(256) : CNT_W'(byte_data);
          sum_d   = '0;
          addr_d  = BASE_ADDRESS;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (xfer) begin
          high_d  = byte_data;
          sum_d   = BYTE_W'(sum_q + byte_data);
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (xfer) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = {high_q, byte_data};
          addr_d  = BYTE_W'(addr_q + BYTE_W'(1));
          cnt_d   = CNT_W'(cnt_q - CNT_W'(1));
          sum_d   = BYTE_W'(sum_q + byte_data);
          state_d = (cnt_q == CNT_W'(1)) ? S_CHECK : S_HIGH;
        end
      end
      S_CHECK: begin
        if (xfer) begin
          if (byte_data == sum_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_COUNT) || (state_d == S_HIGH) ||
              (state_d == S_LOW)   || (state_d == S_CHECK);
  end

  assign byte_ready    = ready_q;
  assign write_enable  = we_q;
  assign write_address = waddr_q;
  assign write_data    = wdata_q;
  assign cpu_hold      = hold_q;
  assign load_done     = done_q;
  assign load_error    = err_q;

endmodule
